img_loader: RTL and testbench
=============================

IMG_LOADER -- requirements
Module: img_loader

Interface
REQ-001 Parameter img_width, default 16, pixel word width.
REQ-002 Parameter IMG_WORDS, default 1024, words per image, i.e. SRAM depth.
REQ-003 clk  input  1  sole clock; all state updates on posedge.
REQ-004 rst  input  1  asynchronous active-low reset; the block is reset while rst is low.
REQ-005 pix_data  input  img_width  incoming pixel word from the ISP.
REQ-006 pix_valid  input  1  pix_data valid; a transfer occurs when pix_valid and pix_ready are both high on a posedge.
REQ-007 pix_sof  input  1  start-of-image marker, qualified by pix_valid.
REQ-008 pix_ready  output  1  block can accept a word this cycle.
REQ-009 img_request1, img_request2  input  1 each  per-bank request from the downstream control stage; high = bank may be (re)filled.
REQ-010 sram_addr  output  10  write address, shared by both banks.
REQ-011 sram_dout  output  img_width  write data, shared by both banks.
REQ-012 sram_en1, sram_wr1, sram_en2, sram_wr2  output  1 each  per-bank chip select and write enable, both active-low.
REQ-013 pre_sram_full1, pre_sram_full2  output  1 each  bank holds a complete image.
REQ-014 sof_err  output  1  one-cycle pulse on a misplaced start-of-image.

Function
REQ-015 State machine: IDLE, FILL1, FILL2, one-hot, held in a single registered state variable.
REQ-016 IDLE -> FILL1 when the next-bank pointer is 1, pre_sram_full1=0 and img_request1=1.
REQ-017 IDLE -> FILL2 under the same rule for bank 2; the next-bank pointer is 1 after reset.
REQ-018 Otherwise IDLE holds; banks strictly alternate, with no skipping even if the other bank is free.
REQ-019 pix_ready = 1 exactly when the state is FILL1 or FILL2 (combinational from state).
REQ-020 Each accepted word drives sram_addr=word counter, sram_dout=pix_data and the active bank's en/wr=0 for exactly one cycle, all registered (one-cycle write latency).
REQ-021 In every cycle without an accepted word, all en/wr outputs are 1.
REQ-022 Word counter: 10 bits, increments per accepted word.
REQ-023 When the accepted word is at count IMG_WORDS-1, the counter wraps to 0, the state returns to IDLE, the next-bank pointer toggles, and the active bank's full flag is set one cycle later, aligned with the final write strobe.
REQ-024 pix_ready drops in the cycle after the final word, so no extra word is accepted.
REQ-025 pix_sof accepted with counter != 0: that word is written at address 0, the counter continues from 1, and sof_err pulses high for one cycle; the partial image is overwritten.
REQ-026 pix_sof accepted with counter == 0: normal write, no error.
REQ-027 Full flag n clears on a detected rising edge of img_requestn (registered previous value 0, current 1).
REQ-028 If a full-set and a rising-edge clear hit the same bank in the same cycle, the set wins.
REQ-029 img_requestn going low has no effect on a fill already in progress; it only gates entry from IDLE.

Reset
REQ-030 On reset: state=IDLE, next-bank pointer=1, counter=0, sram_addr=0, sram_dout=0, all sram_en*/sram_wr*=1, pre_sram_full1/2=0, sof_err=0, edge-detect registers=0, pix_ready=0.
REQ-031 Reset asserted mid-fill discards the partial image; after release, filling restarts at bank 1, address 0.

Verification
REQ-032 Reset release with img_request1=1 and a continuous pix_valid stream of 0..1023 -> bank 1 receives addr k / data k with single-cycle en1=wr1=0; pre_sram_full1=1 on the cycle of the addr-1023 write; exactly 1024 words accepted.
REQ-033 With bank 1 full and img_request2=1 -> the next 1024 words go to bank 2 and en1/wr1 stay 1 throughout; then, with img_request1 held 0, the block stays in IDLE with pix_ready=0.
REQ-034 img_request1 toggled 1->0->1 while full1=1 -> full1 clears on the cycle after the rising edge; the next fill targets bank 1.
REQ-035 pix_sof on the 300th word -> that word is written at addr 0, sof_err is high for 1 cycle, and the following word is written at addr 1.
REQ-036 Bursty pix_valid (1 cycle on, 2 off) -> addresses stay contiguous, with no writes on idle cycles.
REQ-037 rst pulsed low at word 500 -> all outputs return to reset values immediately; the next image lands in bank 1 starting at addr 0.

Source files
------------

// File: rtl/img_loader_if.sv
// img_loader_if -- bundles the pixel-stream handshake and the dual-bank SRAM
// write bus of img_loader into one connection.
//   pix_data/pix_valid/pix_sof : ISP word stream into the loader
//   pix_ready                  : loader can take a word this cycle
//   img_request1/2             : downstream per-bank refill requests
//   sram_addr/sram_dout        : shared write address / data to both banks
//   sram_en*/sram_wr*          : per-bank chip select / write enable, active-low
//   pre_sram_full1/2           : bank holds a complete image
//   sof_err                    : one-cycle pulse on a misplaced start-of-image
// Modports: master = stream source / SRAM side (bench), slave = img_loader.
interface img_loader_if #(
  parameter int img_width = 16
);
  logic [img_width-1:0] pix_data;
  logic                 pix_valid;
  logic                 pix_sof;
  logic                 pix_ready;
  logic                 img_request1;
  logic                 img_request2;
  logic [9:0]           sram_addr;
  logic [img_width-1:0] sram_dout;
  logic                 sram_en1;
  logic                 sram_wr1;
  logic                 sram_en2;
  logic                 sram_wr2;
  logic                 pre_sram_full1;
  logic                 pre_sram_full2;
  logic                 sof_err;

  modport master (
    output pix_data, pix_valid, pix_sof, img_request1, img_request2,
    input  pix_ready, sram_addr, sram_dout, sram_en1, sram_wr1,
           sram_en2, sram_wr2, pre_sram_full1, pre_sram_full2, sof_err
  );

  modport slave (
    input  pix_data, pix_valid, pix_sof, img_request1, img_request2,
    output pix_ready, sram_addr, sram_dout, sram_en1, sram_wr1,
           sram_en2, sram_wr2, pre_sram_full1, pre_sram_full2, sof_err
  );
endinterface

// File: rtl/img_loader.sv
// img_loader -- streams ISP pixel words into two alternating SRAM banks
// (ping-pong). Each bank receives IMG_WORDS words; a bank is refilled only
// after its full flag has been cleared by a rising edge of its request.
// Ports:
//   clk  : sole clock, all state on posedge
//   rst  : asynchronous active-low reset
//   bus  : img_loader_if.slave (pixel handshake + SRAM write bus)
// All SRAM-side outputs are registered: a word accepted on a posedge appears
// on sram_addr/sram_dout with its bank strobe low in the following cycle.
module img_loader #(
  parameter int img_width = 16,
  parameter int IMG_WORDS = 1024
) (
  input  logic         clk,
  input  logic         rst,
  img_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    FILL1 = 3'b010,
    FILL2 = 3'b100
  } state_t;

  localparam logic [9:0] LAST_ADDR = 10'(IMG_WORDS - 1);

  state_t               state_q, state_d;
  logic                 bank2_next_q, bank2_next_d;  // 0: bank 1 is next
  logic [9:0]           cnt_q, cnt_d;
  logic [9:0]           addr_q, addr_d;
  logic [img_width-1:0] dout_q, dout_d;
  logic                 stb1_n_q, stb1_n_d;
  logic                 stb2_n_q, stb2_n_d;
  logic                 full1_q, full1_d;
  logic                 full2_q, full2_d;
  logic                 sof_err_q, sof_err_d;
  logic                 req1_prev_q, req2_prev_q;

  logic                 ready;
  logic                 accept;
  logic                 sof_restart;
  logic [9:0]           wr_addr;
  logic                 last_word;
  logic                 set1, set2;
  logic                 rise1, rise2;

  assign ready  = (state_q == FILL1) || (state_q == FILL2);
  assign accept = bus.pix_valid && ready;

  // A start-of-image mid-image restarts the image at address 0.
  assign sof_restart = accept && bus.pix_sof && (cnt_q != '0);
  assign wr_addr     = sof_restart ? '0 : cnt_q;
  assign last_word   = accept && (wr_addr == LAST_ADDR);

  assign rise1 = bus.img_request1 && !req1_prev_q;
  assign rise2 = bus.img_request2 && !req2_prev_q;

  always_comb begin
    state_d      = state_q;
    bank2_next_d = bank2_next_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    dout_d       = dout_q;
    stb1_n_d     = 1'b1;
    stb2_n_d     = 1'b1;
    sof_err_d    = 1'b0;
    set1         = 1'b0;
    set2         = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Strict alternation: only the pointed-to bank may start a fill.
        if (!bank2_next_q && !full1_q && bus.img_request1) begin
          state_d = FILL1;
        end else if (bank2_next_q && !full2_q && bus.img_request2) begin
          state_d = FILL2;
        end
      end
      FILL1, FILL2: begin
        if (accept) begin
          addr_d    = wr_addr;
          dout_d    = bus.pix_data;
          sof_err_d = sof_restart;
          if (state_q == FILL1) stb1_n_d = 1'b0;
          else                  stb2_n_d = 1'b0;
          if (last_word) begin
            cnt_d        = '0;
            state_d      = IDLE;
            bank2_next_d = !bank2_next_q;
            set1         = (state_q == FILL1);
            set2         = (state_q == FILL2);
          end else begin
            cnt_d = wr_addr + 10'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Set is registered alongside the final strobe and beats a same-cycle clear.
    full1_d = set1 || (full1_q && !rise1);
    full2_d = set2 || (full2_q && !rise2);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      bank2_next_q <= 1'b0;
      cnt_q        <= '0;
      addr_q       <= '0;
      dout_q       <= '0;
      stb1_n_q     <= 1'b1;
      stb2_n_q     <= 1'b1;
      full1_q      <= 1'b0;
      full2_q      <= 1'b0;
      sof_err_q    <= 1'b0;
      req1_prev_q  <= 1'b0;
      req2_prev_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bank2_next_q <= bank2_next_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      dout_q       <= dout_d;
      stb1_n_q     <= stb1_n_d;
      stb2_n_q     <= stb2_n_d;
      full1_q      <= full1_d;
      full2_q      <= full2_d;
      sof_err_q    <= sof_err_d;
      req1_prev_q  <= bus.img_request1;
      req2_prev_q  <= bus.img_request2;
    end
  end

  assign bus.pix_ready      = ready;
  assign bus.sram_addr      = addr_q;
  assign bus.sram_dout      = dout_q;
  assign bus.sram_en1       = stb1_n_q;
  assign bus.sram_wr1       = stb1_n_q;
  assign bus.sram_en2       = stb2_n_q;
  assign bus.sram_wr2       = stb2_n_q;
  assign bus.pre_sram_full1 = full1_q;
  assign bus.pre_sram_full2 = full2_q;
  assign bus.sof_err        = sof_err_q;

endmodule

// File: tb/tb_img_loader.sv
// tb_img_loader -- directed, self-checking bench for img_loader.
// A vector table covers the start of a fill (bursty valid, start-of-image
// handling); hand-written sequences cover full-image fills, bank alternation,
// full-flag clearing, set/clear collision and mid-fill reset.
module tb_img_loader;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  img_loader_if #(.img_width(16)) bus ();

  img_loader #(
    .img_width(16),
    .IMG_WORDS(1024)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        s;
    logic        r1;
    logic [15:0] d;
    logic        e_rdy;
    logic        e_wr;
    logic [9:0]  e_addr;
    logic        e_se;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] strobes();
    return {bus.sram_en1, bus.sram_wr1, bus.sram_en2, bus.sram_wr2};
  endfunction

  // Continuous-valid fill; words carry data == address (base + index).
  task automatic run_fill(input int bank, input int base, input int nwords, input int budget,
                          input logic other_full, input bit req2_drop, input bit clash,
                          output int acc);
    logic       rdy;
    logic       f_this;
    logic [3:0] e_stb;
    acc = 0;
    for (int c = 0; c < budget && acc < nwords; c++) begin
      bus.pix_valid = 1'b1;
      bus.pix_sof   = 1'b0;
      bus.pix_data  = 16'(base + acc);
      if (req2_drop && acc == 600) bus.img_request2 = 1'b0;
      if (clash && acc == nwords - 2) bus.img_request1 = 1'b0;
      if (clash && acc == nwords - 1) bus.img_request1 = 1'b1;
      rdy = bus.pix_ready;
      step();
      if (rdy) begin
        f_this = ((base + acc) == 1023);
        e_stb  = (bank == 1) ? 4'b0011 : 4'b1100;
        chk($sformatf("fill%0d_stb_w%0d", bank, base + acc), 32'(strobes()), 32'(e_stb));
        chk($sformatf("fill%0d_addr_w%0d", bank, base + acc), 32'(bus.sram_addr), 32'(base + acc));
        chk($sformatf("fill%0d_dout_w%0d", bank, base + acc), 32'(bus.sram_dout), 32'(base + acc));
        chk($sformatf("fill%0d_full_w%0d", bank, base + acc),
            32'({bus.pre_sram_full1, bus.pre_sram_full2}),
            32'((bank == 1) ? {f_this, other_full} : {other_full, f_this}));
        chk($sformatf("fill%0d_soferr_w%0d", bank, base + acc), 32'(bus.sof_err), 32'(0));
        acc++;
      end else begin
        chk($sformatf("fill%0d_idle_stb_c%0d", bank, c), 32'(strobes()), 32'(4'hF));
      end
    end
    bus.pix_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(bus.pix_ready), 32'(0));
    chk({tag, "_addr"},  32'(bus.sram_addr), 32'(0));
    chk({tag, "_dout"},  32'(bus.sram_dout), 32'(0));
    chk({tag, "_stb"},   32'(strobes()), 32'(4'hF));
    chk({tag, "_full"},  32'({bus.pre_sram_full1, bus.pre_sram_full2}), 32'(0));
    chk({tag, "_soferr"}, 32'(bus.sof_err), 32'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;

    //            v     s     r1    data      rdy   wr    addr    sof_err
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'h00AA, 1'b0, 1'b0, 10'd0, 1'b0}; // no request: stay idle
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 16'h00AB, 1'b0, 1'b0, 10'd0, 1'b0}; // enter FILL1
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 16'h0010, 1'b1, 1'b1, 10'd0, 1'b0}; // sof at count 0: normal
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 10'd0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 16'h0011, 1'b1, 1'b1, 10'd1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 10'd0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 10'd0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 16'h0012, 1'b1, 1'b1, 10'd2, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 16'h0013, 1'b1, 1'b1, 10'd0, 1'b1}; // misplaced sof
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 16'h0014, 1'b1, 1'b1, 10'd1, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 16'h0015, 1'b1, 1'b1, 10'd2, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 10'd0, 1'b0}; // sof without valid
    tbl[12] = '{1'b1, 1'b0, 1'b1, 16'h0016, 1'b1, 1'b1, 10'd3, 1'b0};

    rst              = 1'b0;
    bus.pix_data     = '0;
    bus.pix_valid    = 1'b0;
    bus.pix_sof      = 1'b0;
    bus.img_request1 = 1'b0;
    bus.img_request2 = 1'b0;
    repeat (3) step();
    chk_reset_vals("por");
    rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      bus.pix_valid    = tbl[i].v;
      bus.pix_sof      = tbl[i].s;
      bus.img_request1 = tbl[i].r1;
      bus.pix_data     = tbl[i].d;
      chk($sformatf("tbl%0d_ready", i), 32'(bus.pix_ready), 32'(tbl[i].e_rdy));
      step();
      chk($sformatf("tbl%0d_stb", i), 32'(strobes()),
          32'(tbl[i].e_wr ? 4'b0011 : 4'b1111));
      chk($sformatf("tbl%0d_soferr", i), 32'(bus.sof_err), 32'(tbl[i].e_se));
      if (tbl[i].e_wr) begin
        chk($sformatf("tbl%0d_addr", i), 32'(bus.sram_addr), 32'(tbl[i].e_addr));
        chk($sformatf("tbl%0d_dout", i), 32'(bus.sram_dout), 32'(tbl[i].d));
      end
    end
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;

    // Rest of image 1 (addresses 4..1023) with img_request1 held high.
    run_fill(1, 4, 1020, 1100, 1'b0, 1'b0, 1'b0, acc);
    chk("fill1_rest_count", 32'(acc), 32'(1020));
    chk("after_fill1_ready", 32'(bus.pix_ready), 32'(0));

    // Bank 2 fill; request 2 drops mid-fill without effect.
    bus.img_request1 = 1'b0;
    bus.img_request2 = 1'b1;
    run_fill(2, 0, 1024, 1100, 1'b1, 1'b1, 1'b0, acc);
    chk("fill2_count", 32'(acc), 32'(1024));

    // Both full, request 1 low: must idle.
    for (int i = 0; i < 8; i++) begin
      bus.pix_valid = 1'b1;
      chk($sformatf("idle_ready_%0d", i), 32'(bus.pix_ready), 32'(0));
      step();
      chk($sformatf("idle_stb_%0d", i), 32'(strobes()), 32'(4'hF));
    end
    bus.pix_valid = 1'b0;
    chk("idle_full", 32'({bus.pre_sram_full1, bus.pre_sram_full2}), 32'(2'b11));

    // Rising edge on request 1 clears full1 one cycle later, then bank 1 refills.
    bus.img_request1 = 1'b1;
    chk("rise_full1_before", 32'(bus.pre_sram_full1), 32'(1));
    step();
    chk("rise_full1_after", 32'(bus.pre_sram_full1), 32'(0));
    chk("rise_ready_after", 32'(bus.pix_ready), 32'(0));
    step();
    chk("refill1_ready", 32'(bus.pix_ready), 32'(1));

    // Partial image of 500 words, then asynchronous reset mid-fill.
    run_fill(1, 0, 500, 600, 1'b1, 1'b0, 1'b0, acc);
    chk("partial_count", 32'(acc), 32'(500));
    rst = 1'b0;
    #1;
    chk_reset_vals("midrst");
    step();
    rst = 1'b1;

    // Full image after reset lands in bank 1 from address 0; a request-1 rising
    // edge coincides with the final word, where the set must win.
    run_fill(1, 0, 1024, 1100, 1'b0, 1'b0, 1'b1, acc);
    chk("postrst_count", 32'(acc), 32'(1024));
    chk("postrst_ready", 32'(bus.pix_ready), 32'(0));
    step();
    chk("clash_full1_hold", 32'(bus.pre_sram_full1), 32'(1));
    chk("clash_stb_idle", 32'(strobes()), 32'(4'hF));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
